rv32i_memaccess: RTL and testbench
==================================

# rv32i_memaccess

Memory-access stage of the RV32I pipeline, directly downstream of the ALU stage. Consumes the ALU result (effective address or pass-through rd value), store data, funct3 and load/store qualifiers, and runs one pipelined-Wishbone data-bus transaction per load/store. Produces the aligned, sign/zero-extended load result or the forwarded ALU value for writeback. Stalls the ALU stage while a bus transaction is outstanding.

## Interface
- TIMEOUT, 16: cycles in REQ+WAIT without `i_wb_ack` before the access is aborted as a bus error.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_ce  in  1  ALU stage output valid.
- i_is_load / i_is_store  in  1 each  op qualifiers; never both high.
- i_y  in  32  effective address for load/store.
- i_rs2  in  32  store data.
- i_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_wr_rd  in  1  writeback enable for the current op.
- i_rd_addr  in  5  destination register.
- i_rd  in  32  pass-through result for non-memory ops.
- i_stall  in  1  writeback stage stall.
- i_flush  in  1  squash.
- o_ce  out  1  result valid.
- o_wr_rd  out  1  writeback enable.
- o_rd_addr  out  5  destination register.
- o_rd  out  32  result.
- o_exc_misaligned  out  1  misaligned access, qualified by o_ce.
- o_exc_bus_err  out  1  timeout, qualified by o_ce.
- o_stall_from_mem  out  1  upstream hold.
- o_wb_cyc / o_wb_stb / o_wb_we  out  1 each  bus controls.
- o_wb_addr  out  32  `{addr[31:2],2'b00}`.
- o_wb_data  out  32  store data.
- o_wb_sel  out  4  byte lanes.
- i_wb_ack / i_wb_stall  in  1 each  bus handshake.
- i_wb_data  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT. `o_stall_from_mem = (state != IDLE)`.
- Acceptance: in IDLE with `i_ce && !i_stall && !i_flush`. All request fields are latched on acceptance. Inputs presented while busy or stalled are ignored until acceptance.
- Non-memory op accepted: next cycle `o_ce=1`, `o_rd=i_rd`, `o_wr_rd=i_wr_rd`, `o_rd_addr=i_rd_addr`. No bus activity.
- Misalignment check:
  - H/HU misaligned when `addr[0]=1`.
  - W misaligned when `addr[1:0]!=0`.
  - Misaligned op: no bus cycle; next cycle `o_ce=1`, `o_exc_misaligned=1`, `o_wr_rd=0`.
- Aligned load/store: IDLE→REQ with `cyc=stb=1`.
  - `sel`: B `4'b0001<<addr[1:0]`; H `4'b0011<<addr[1:0]`; W `4'b1111`.
  - `o_wb_data`: B `{4{rs2[7:0]}}`; H `{2{rs2[15:0]}}`; W `rs2`.
  - `we=1` for stores.
- REQ: when `!i_wb_stall`, stb drops next cycle and the FSM moves to WAIT. WAIT: cyc held until `i_wb_ack`, then cyc drops and the FSM returns to IDLE.
- On ack:
  - Load: `o_rd` = the lane selected by `addr[1:0]` from `i_wb_data`, sign-extended (B, H) or zero-extended (BU, HU); `o_wr_rd=i_wr_rd`.
  - Store: `o_wr_rd=0`.
  - `o_ce=1` the cycle after ack.
- Timeout: a counter clears on entering REQ and increments each cycle in REQ or WAIT. At count TIMEOUT-1 with no ack, next cycle: cyc/stb drop, FSM returns to IDLE, `o_ce=1`, `o_exc_bus_err=1`, `o_wr_rd=0`.
- `i_stall` high: output registers and `o_ce` hold. The bus transaction keeps running; its result waits in an internal holding register and is presented once `i_stall` falls.
- `i_flush`:
  - In IDLE: incoming op dropped.
  - In REQ: stb not yet accepted, so cyc/stb drop next cycle, FSM returns to IDLE, no o_ce.
  - In WAIT: bus cycle completes normally; the result is discarded (no o_ce).
  - `o_ce` clears next cycle in all cases.

## Timing
- Reset: all outputs 0 immediately, including `o_wb_cyc`; state IDLE; counter 0. Reset mid-transaction abandons it.
- Non-memory op: latency 1.
- Aligned load or store with a zero-wait slave: accept at cycle 0; `cyc=stb=1` in cycle 1; ack in cycle 2; `o_ce` in cycle 3; `o_stall_from_mem` high in cycles 1–2.
- Each `i_wb_stall` cycle extends REQ by 1. Ack is never sampled in the same cycle stb is first accepted.
- Back-to-back: the next op may be accepted in the same cycle the FSM is back in IDLE (the cycle `o_ce` rises).

## Test plan
- ADD result `0x1234` to rd 5, no memory → one cycle later `o_ce=1`, `o_rd=0x1234`, `o_rd_addr=5`, no `o_wb_cyc`.
- LB at `0x1003`, slave returns `0x80FFFFFF` with ack 1 cycle after stb → `o_wb_sel=4'b1000`, `o_rd=0xFFFFFF80`. LBU at the same address → `0x00000080`.
- SH `rs2=0xABCD1234` at `0x2002` with 2 `i_wb_stall` cycles → `o_wb_data=0x12341234`, `o_wb_sel=4'b1100`, `o_wb_we=1`, stb held 3 cycles, `o_wr_rd=0`.
- LW at `0x3001` → no bus cycle, `o_ce=1`, `o_exc_misaligned=1`, `o_wr_rd=0`.
- Load with the slave never acking, TIMEOUT=16 → cyc drops after 16 cycles, `o_exc_bus_err=1`.
- Flush in WAIT on a load → ack consumed, `o_ce` stays 0. Reset asserted in REQ → `o_wb_cyc=0` immediately, FSM in IDLE.

Source files
------------

// File: rtl/rv32i_memaccess.sv
// RV32I memory-access stage: runs one pipelined-Wishbone transaction per
// load/store, aligns and extends load data, forwards non-memory results,
// and stalls the ALU stage while a bus transaction is outstanding.
//
// Handshakes: an op is taken from the ALU stage only in IDLE when
// i_ce && !i_stall && !i_flush (o_stall_from_mem is the ready-low signal).
// On the bus, stb is accepted in a cycle where stb && !i_wb_stall, and the
// access completes in a WAIT cycle where i_wb_ack is high. Results leave on
// o_ce and are held unchanged while i_stall is high.
module rv32i_memaccess #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [31:0] i_y,
    input  logic [31:0] i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic        i_wr_rd,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic        o_ce,
    output logic        o_wr_rd,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd,
    output logic        o_exc_misaligned,
    output logic        o_exc_bus_err,
    output logic        o_stall_from_mem,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data,
    output logic [1:0]  o_dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic        wr_rd;
        logic [4:0]  rd_addr;
        logic [31:0] rd;
        logic        exc_mis;
        logic        exc_bus;
    } result_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              accept, is_mem, misaligned, timeout, discard;
    logic              load_q, wr_rd_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic [4:0]        rd_addr_q;
    logic [3:0]        sel_req;
    logic [31:0]       data_req, lane, load_val;
    result_t           res, hold, out_r;
    logic              res_v, hold_valid, ce_r;

    assign accept  = (state == IDLE) && i_ce && !i_stall && !i_flush;
    assign is_mem  = i_is_load || i_is_store;
    // In REQ ack is never sampled; in WAIT an ack on the last cycle wins.
    assign timeout = (cnt == CNT_W'(TIMEOUT - 1)) &&
                     ((state == REQ) || ((state == WAIT) && !i_wb_ack));

    // Alignment check, byte lanes and replicated store data for the new op.
    always_comb begin
        misaligned = 1'b0;
        sel_req    = 4'b1111;
        data_req   = i_rs2;
        case (i_funct3[1:0])
            2'b00: begin
                sel_req  = 4'b0001 << i_y[1:0];
                data_req = {4{i_rs2[7:0]}};
            end
            2'b01: begin
                misaligned = i_y[0];
                sel_req    = 4'b0011 << i_y[1:0];
                data_req   = {2{i_rs2[15:0]}};
            end
            default: misaligned = (i_y[1:0] != 2'b00);
        endcase
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        lane = i_wb_data >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'd0, lane[7:0]};
            3'b101:  load_val = {16'd0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && is_mem && !misaligned) state_nxt = REQ;
            REQ: begin
                if (i_flush || timeout)  state_nxt = IDLE;
                else if (!i_wb_stall)    state_nxt = WAIT;
            end
            WAIT: if (i_wb_ack || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result produced this cycle: immediate ops, bus completion or bus error.
    // The misaligned case reports the faulting address on o_rd.
    always_comb begin
        res   = '0;
        res_v = 1'b0;
        if (accept && (!is_mem || misaligned)) begin
            res_v         = 1'b1;
            res.rd_addr   = i_rd_addr;
            res.wr_rd     = !is_mem && i_wr_rd;
            res.rd        = is_mem ? i_y : i_rd;
            res.exc_mis   = is_mem;
        end else if ((state == WAIT) && i_wb_ack && !discard && !i_flush) begin
            res_v         = 1'b1;
            res.rd_addr   = rd_addr_q;
            res.wr_rd     = load_q && wr_rd_q;
            res.rd        = load_q ? load_val : 32'd0;
        end else if (timeout && !discard && !i_flush) begin
            res_v         = 1'b1;
            res.rd_addr   = rd_addr_q;
            res.exc_bus   = 1'b1;
        end
    end

    // FSM state register, timeout counter and squash flag for WAIT flushes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            discard <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                cnt     <= '0;
                discard <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
                if ((state == WAIT) && i_flush) discard <= 1'b1;
            end
        end
    end

    // Latch request fields and bus attributes when an op is accepted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            load_q    <= 1'b0;
            wr_rd_q   <= 1'b0;
            funct3_q  <= 3'd0;
            off_q     <= 2'd0;
            rd_addr_q <= 5'd0;
            o_wb_we   <= 1'b0;
            o_wb_addr <= 32'd0;
            o_wb_data <= 32'd0;
            o_wb_sel  <= 4'd0;
        end else if (accept) begin
            load_q    <= i_is_load;
            wr_rd_q   <= i_wr_rd;
            funct3_q  <= i_funct3;
            off_q     <= i_y[1:0];
            rd_addr_q <= i_rd_addr;
            o_wb_we   <= i_is_store;
            o_wb_addr <= {i_y[31:2], 2'b00};
            o_wb_data <= data_req;
            o_wb_sel  <= sel_req;
        end
    end

    // Output registers with a one-entry holding slot. While i_stall is high
    // the outputs freeze and a finishing bus access parks in the slot; the
    // slot drains first once the stall clears, so an op accepted in that same
    // cycle simply takes the slot's place.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ce_r       <= 1'b0;
            out_r      <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (i_flush) begin
            ce_r       <= 1'b0;
            hold_valid <= 1'b0;
        end else if (!i_stall) begin
            if (hold_valid) begin
                out_r      <= hold;
                ce_r       <= 1'b1;
                hold       <= res;
                hold_valid <= res_v;
            end else begin
                ce_r <= res_v;
                if (res_v) out_r <= res;
            end
        end else if (res_v) begin
            hold       <= res;
            hold_valid <= 1'b1;
        end
    end

    assign o_ce             = ce_r;
    assign o_wr_rd          = out_r.wr_rd;
    assign o_rd_addr        = out_r.rd_addr;
    assign o_rd             = out_r.rd;
    assign o_exc_misaligned = out_r.exc_mis;
    assign o_exc_bus_err    = out_r.exc_bus;
    assign o_wb_cyc         = (state != IDLE);
    assign o_wb_stb         = (state == REQ);
    assign o_stall_from_mem = (state != IDLE);
    assign o_dbg_state      = state;

endmodule

// File: tb/tb_rv32i_memaccess.sv
// Directed testbench for rv32i_memaccess with hand-computed expectations.
module tb_rv32i_memaccess;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ce, i_is_load, i_is_store, i_wr_rd, i_stall, i_flush;
    logic [31:0] i_y, i_rs2, i_rd;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd_addr;
    logic        o_ce, o_wr_rd, o_exc_misaligned, o_exc_bus_err, o_stall_from_mem;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack, i_wb_stall;
    logic [31:0] i_wb_data;
    logic [1:0]  o_dbg_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    rv32i_memaccess #(.TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_ce(i_ce),
        .i_is_load(i_is_load), .i_is_store(i_is_store),
        .i_y(i_y), .i_rs2(i_rs2), .i_funct3(i_funct3),
        .i_wr_rd(i_wr_rd), .i_rd_addr(i_rd_addr), .i_rd(i_rd),
        .i_stall(i_stall), .i_flush(i_flush),
        .o_ce(o_ce), .o_wr_rd(o_wr_rd), .o_rd_addr(o_rd_addr), .o_rd(o_rd),
        .o_exc_misaligned(o_exc_misaligned), .o_exc_bus_err(o_exc_bus_err),
        .o_stall_from_mem(o_stall_from_mem),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data),
        .o_dbg_state(o_dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [31:0] y,
                            input logic [31:0] rs2, input logic [2:0] f3,
                            input logic wr, input logic [4:0] rda, input logic [31:0] rd);
        i_ce = 1'b1; i_is_load = ld; i_is_store = st; i_y = y; i_rs2 = rs2;
        i_funct3 = f3; i_wr_rd = wr; i_rd_addr = rda; i_rd = rd;
    endtask

    task automatic idle_op();
        i_ce = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
    endtask

    // Scoreboard check of a presented result; rd comes from exp_q when use_q.
    task automatic check_result(input string tag, input logic wr, input logic mis,
                                input logic berr, input logic [4:0] rda, input logic use_q);
        logic [31:0] e;
        chk({tag, "_ce"}, 32'(o_ce), 32'd1);
        chk({tag, "_wr"}, 32'(o_wr_rd), 32'(wr));
        chk({tag, "_rda"}, 32'(o_rd_addr), 32'(rda));
        chk({tag, "_mis"}, 32'(o_exc_misaligned), 32'(mis));
        chk({tag, "_berr"}, 32'(o_exc_bus_err), 32'(berr));
        if (use_q) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            chk({tag, "_rd"}, o_rd, e);
        end
    endtask

    // One aligned load/store with `stalls` slave stall cycles and an ack right after.
    task automatic mem_op(input string tag, input logic st, input logic [31:0] y,
                          input logic [31:0] rs2, input logic [2:0] f3, input int stalls,
                          input logic [31:0] rdata, input logic [3:0] exp_sel,
                          input logic [31:0] exp_data, input logic [31:0] exp_rd);
        int n;
        drive_op(!st, st, y, rs2, f3, 1'b1, 5'd7, 32'h0);
        if (!st) exp_q.push_back(exp_rd);
        tick();
        idle_op();
        chk({tag, "_cyc"}, 32'(o_wb_cyc), 32'd1);
        chk({tag, "_stb"}, 32'(o_wb_stb), 32'd1);
        chk({tag, "_sel"}, 32'(o_wb_sel), 32'(exp_sel));
        chk({tag, "_we"}, 32'(o_wb_we), 32'(st));
        chk({tag, "_addr"}, o_wb_addr, {y[31:2], 2'b00});
        chk({tag, "_hold"}, 32'(o_stall_from_mem), 32'd1);
        if (st) chk({tag, "_data"}, o_wb_data, exp_data);
        n = 0;
        while (o_wb_stb && n < 20) begin
            n++;
            i_wb_stall = (n <= stalls);
            tick();
        end
        i_wb_stall = 1'b0;
        chk({tag, "_stb_len"}, 32'(n), 32'(stalls + 1));
        chk({tag, "_wait_cyc"}, 32'(o_wb_cyc), 32'd1);
        i_wb_ack = 1'b1;
        i_wb_data = rdata;
        tick();
        i_wb_ack = 1'b0;
        i_wb_data = 32'h0;
        check_result(tag, !st, 1'b0, 1'b0, 5'd7, !st);
        chk({tag, "_cyc_end"}, 32'(o_wb_cyc), 32'd0);
        chk({tag, "_hold_end"}, 32'(o_stall_from_mem), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        idle_op();
        i_y = 0; i_rs2 = 0; i_funct3 = 0; i_wr_rd = 0; i_rd_addr = 0; i_rd = 0;
        i_stall = 0; i_flush = 0; i_wb_ack = 0; i_wb_stall = 0; i_wb_data = 0;
        repeat (3) tick();
        chk("rst_ce", 32'(o_ce), 32'd0);
        chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
        chk("rst_state", 32'(o_dbg_state), 32'd0);
        rst = 1'b0;
        tick();

        // ADD -> rd5 = 0x1234, latency 1, no bus
        drive_op(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 5'd5, 32'h1234);
        exp_q.push_back(32'h1234);
        tick();
        idle_op();
        check_result("add", 1'b1, 1'b0, 1'b0, 5'd5, 1'b1);
        chk("add_cyc", 32'(o_wb_cyc), 32'd0);
        tick();
        chk("add_ce_drop", 32'(o_ce), 32'd0);

        // LB / LBU at 0x1003, byte lane 3 = 0x80
        mem_op("lb", 1'b0, 32'h1003, 32'h0, 3'b000, 0, 32'h80FFFFFF, 4'b1000, 32'h0, 32'hFFFFFF80);
        mem_op("lbu", 1'b0, 32'h1003, 32'h0, 3'b100, 0, 32'h80FFFFFF, 4'b1000, 32'h0, 32'h00000080);

        // SH at 0x2002 with two slave stall cycles
        mem_op("sh", 1'b1, 32'h2002, 32'hABCD1234, 3'b001, 2, 32'h0, 4'b1100, 32'h12341234, 32'h0);

        // LH / LHU upper half, SB lane 1, LW aligned
        mem_op("lh", 1'b0, 32'h2002, 32'h0, 3'b001, 0, 32'h80015555, 4'b1100, 32'h0, 32'hFFFF8001);
        mem_op("lhu", 1'b0, 32'h2002, 32'h0, 3'b101, 1, 32'h80015555, 4'b1100, 32'h0, 32'h00008001);
        mem_op("sb", 1'b1, 32'h2001, 32'h000000A5, 3'b000, 0, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0);
        mem_op("lw", 1'b0, 32'h2004, 32'h0, 3'b010, 0, 32'h12345678, 4'b1111, 32'h0, 32'h12345678);

        // Back-to-back: ADD accepted in the cycle the LW result appears
        drive_op(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 5'd9, 32'h55);
        exp_q.push_back(32'h55);
        tick();
        idle_op();
        check_result("b2b", 1'b1, 1'b0, 1'b0, 5'd9, 1'b1);

        // Misaligned LW and LH: no bus, exception
        drive_op(1'b1, 1'b0, 32'h3001, 32'h0, 3'b010, 1'b1, 5'd3, 32'h0);
        tick();
        idle_op();
        check_result("lw_mis", 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
        chk("lw_mis_cyc", 32'(o_wb_cyc), 32'd0);
        drive_op(1'b1, 1'b0, 32'h3003, 32'h0, 3'b001, 1'b1, 5'd4, 32'h0);
        tick();
        idle_op();
        check_result("lh_mis", 1'b0, 1'b1, 1'b0, 5'd4, 1'b0);
        chk("lh_mis_cyc", 32'(o_wb_cyc), 32'd0);
        tick();

        // Timeout: slave never acks
        drive_op(1'b1, 1'b0, 32'h4000, 32'h0, 3'b010, 1'b1, 5'd6, 32'h0);
        tick();
        idle_op();
        n = 0;
        while (o_wb_cyc && n < 40) begin
            n++;
            tick();
        end
        chk("to_len", 32'(n), 32'd16);
        check_result("to", 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
        tick();

        // Writeback stall while the load completes: result parked, then presented
        drive_op(1'b1, 1'b0, 32'h5000, 32'h0, 3'b010, 1'b1, 5'd7, 32'h0);
        exp_q.push_back(32'hCAFEF00D);
        tick();
        idle_op();
        tick();
        i_stall = 1'b1;
        i_wb_ack = 1'b1;
        i_wb_data = 32'hCAFEF00D;
        tick();
        i_wb_ack = 1'b0;
        chk("stl_ce0", 32'(o_ce), 32'd0);
        chk("stl_cyc", 32'(o_wb_cyc), 32'd0);
        tick();
        chk("stl_ce1", 32'(o_ce), 32'd0);
        i_stall = 1'b0;
        tick();
        check_result("stl", 1'b1, 1'b0, 1'b0, 5'd7, 1'b1);
        tick();
        chk("stl_ce_drop", 32'(o_ce), 32'd0);

        // Flush in WAIT: ack consumed, no o_ce
        drive_op(1'b1, 1'b0, 32'h6000, 32'h0, 3'b010, 1'b1, 5'd8, 32'h0);
        tick();
        idle_op();
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("fw_cyc", 32'(o_wb_cyc), 32'd1);
        i_wb_ack = 1'b1;
        tick();
        i_wb_ack = 1'b0;
        chk("fw_ce", 32'(o_ce), 32'd0);
        chk("fw_cyc_end", 32'(o_wb_cyc), 32'd0);
        tick();
        chk("fw_ce2", 32'(o_ce), 32'd0);

        // Flush in REQ: cycle abandoned
        drive_op(1'b1, 1'b0, 32'h6004, 32'h0, 3'b010, 1'b1, 5'd8, 32'h0);
        tick();
        idle_op();
        i_wb_stall = 1'b1;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_wb_stall = 1'b0;
        chk("fr_cyc", 32'(o_wb_cyc), 32'd0);
        chk("fr_ce", 32'(o_ce), 32'd0);

        // Flush in IDLE drops the incoming op
        drive_op(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 5'd2, 32'h77);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        idle_op();
        chk("fi_ce", 32'(o_ce), 32'd0);

        // Reset during REQ abandons the access immediately
        drive_op(1'b1, 1'b0, 32'h7000, 32'h0, 3'b010, 1'b1, 5'd1, 32'h0);
        tick();
        idle_op();
        chk("rq_cyc_pre", 32'(o_wb_cyc), 32'd1);
        rst = 1'b1;
        #1;
        chk("rq_cyc", 32'(o_wb_cyc), 32'd0);
        chk("rq_state", 32'(o_dbg_state), 32'd0);
        chk("rq_hold", 32'(o_stall_from_mem), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
